axis_uart_bridge_rx: RTL and testbench
======================================

# axis_uart_bridge_rx

UART-to-AXI-Stream receive bridge: deserialises 8N1 UART frames from a single input line, packs N_BYTES consecutive bytes into one wide word and queues it on an AXI-Stream master port. It is the receive counterpart of the bridge transmitter and sits between an external UART pin and on-chip AXI-Stream consumers. The byte order matches the transmitter, so an RX/TX pair with equal parameters is transparent.

## Interface
- UART_SPEED, 115200, line baud rate
- FREQ_HZ, 100000000, clk frequency
- N_BYTES, 32, bytes per output word; M_AXIS_TDATA width = N_BYTES*8
- QUEUE_DEPTH, 16, output queue depth in words
- QUEUE_MEMTYPE, "block", queue memory type: "block", "distributed" or "auto"
- TIMEOUT_BITS, 32, idle gap in bit periods that aborts a partial word (used only with the timeout feature)
- clk  in  1  single clock
- resetn  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low
- UART_RX  in  1  serial line, asynchronous to clk, idles high
- M_AXIS_TDATA  out  N_BYTES*8  packed word; first received byte is in [7:0]
- M_AXIS_TVALID  out  1  word available
- M_AXIS_TREADY  in  1  consumer accepts
- FRAME_ERROR  out  1  one-cycle pulse on a bad stop bit
- OVERFLOW  out  1  one-cycle pulse when a completed word is dropped because the queue is full

## Operation
- Bit period BIT_CLKS = FREQ_HZ/UART_SPEED, rounded down; HALF_CLKS = BIT_CLKS/2.
- UART_RX passes through a 2-flop synchroniser, which presets to 1 on reset; all logic uses the synchronised value rxs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a rxs 1->0 edge, clear the bit counter and go to START.
  - START: after HALF_CLKS, sample rxs. If 0, go to DATA. If 1 (glitch), go back to IDLE with no error.
  - DATA: sample every BIT_CLKS. Shift each bit into the byte register LSB first. After the 8th bit, go to STOP.
  - STOP: sample after BIT_CLKS.
    - rxs=1: store the byte at slot byte_counter and increment byte_counter.
    - rxs=0: pulse FRAME_ERROR, discard the partial word and set byte_counter to 0.
    - Either way, return to IDLE. The next start edge is detected from the stop-bit midpoint onward.
- When byte_counter reaches N_BYTES, write the packed word to the queue and set byte_counter to 0.
  - If the queue is full, drop the word and pulse OVERFLOW. A stalled consumer never causes a partial word or corrupted data.
- Bytes never straddle words. The word register is not cleared between words; every slot is rewritten before each push.
- AXI-Stream master handshake:
  - A transfer occurs when TVALID and TREADY are both high.
  - TDATA is stable while TVALID=1 and TREADY=0.
  - TVALID never depends combinationally on TREADY.

## Timing
- Reset values:
  - M_AXIS_TVALID=0, FRAME_ERROR=0, OVERFLOW=0.
  - FSM=IDLE, all counters 0, queue empty.
  - M_AXIS_TDATA is don't-care while TVALID=0.
- Reset asserted mid-frame aborts everything immediately. After release, the bridge waits for a fresh 1->0 edge; a line already low at release is ignored until it returns high.
- Input latency: 2 clk through the synchroniser. Sample points fall at HALF_CLKS + k*BIT_CLKS after the synchronised start edge, for k = 0 (start bit) through 9 (stop bit).
- Queue write occurs 1 clk after the final stop-bit sample. M_AXIS_TVALID rises no later than 4 clk after that sample when the queue was empty.
- Simultaneous queue write and read with the queue full: the write is rejected and OVERFLOW pulses. The read completes normally.
- FRAME_ERROR and OVERFLOW are single-cycle pulses, registered, asserted 1 clk after the stop-bit sample.

## Configuration
- AXIS_UART_BRIDGE_RX_TIMEOUT_EN defined:
  - An idle counter runs in IDLE while 0 < byte_counter < N_BYTES.
  - If the counter reaches TIMEOUT_BITS*BIT_CLKS with no start edge, byte_counter is set to 0 and the partial word is discarded silently.
- AXIS_UART_BRIDGE_RX_TIMEOUT_EN undefined: no idle counter; a partial word waits indefinitely for its remaining bytes. TIMEOUT_BITS is ignored.

## Structure
- Shared package axis_uart_bridge_pkg:
  - rx_fsm enum (IDLE_ST, START_ST, DATA_ST, STOP_ST).
  - Function computing BIT_CLKS from FREQ_HZ and UART_SPEED.
  - Byte-slot width constant.
- One sub-module: fifo_out_sync_xpm, the synchronous first-word-fall-through output queue.
  - Write side: data, wren, full.
  - Read side: the M_AXIS_* ports.
  - It receives active-high reset derived from ~resetn.

## Test plan
Bench parameters: FREQ_HZ=100e6, UART_SPEED=10e6 (BIT_CLKS=10), N_BYTES=4, QUEUE_DEPTH=4, TREADY=1 unless stated.
- Send bytes 0x11,0x22,0x33,0x44 back-to-back -> exactly one word 0x44332211; TVALID rises at most 4 clk after the 4th stop sample.
- Send 0xA5 with the stop bit forced low, then 4 good bytes 0x01..0x04 -> FRAME_ERROR pulses once; the only word output is 0x04030201.
- Drive a 3-clk low glitch on an idle line -> no state change, no error, no output.
- Hold TREADY=0 and send 5 words -> the first 4 are queued, OVERFLOW pulses once for the 5th; releasing TREADY drains the 4 words in order.
- Assert resetn low during bit 3 of byte 2, release, then send 4 bytes -> outputs are 0 during reset; only the new word is produced.
- With TIMEOUT_EN, TIMEOUT_BITS=32: send 2 bytes, idle 400 clk, send 4 bytes -> one word containing only the last 4 bytes.

Source files
------------

// File: rtl/axis_uart_bridge_rx_pkg.sv
// Shared definitions for the UART <-> AXI-Stream bridge: receiver FSM encoding,
// byte-slot width and the bit-period helper.
package axis_uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE_ST,
    START_ST,
    DATA_ST,
    STOP_ST
  } rx_fsm;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned bit_clks(input int unsigned freq_hz,
                                           input int unsigned uart_speed);
    return freq_hz / uart_speed;
  endfunction

endpackage

// File: rtl/axis_uart_bridge_rx_if.sv
// AXI-Stream data channel between the bridge output queue and its consumer.
interface axis_uart_bridge_rx_if #(
  parameter int unsigned DATA_W = 256
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_bridge_rx_fifo.sv
// First-word-fall-through output queue; "block" adds a registered read stage,
// other memory types read the array combinationally.
module fifo_out_sync_xpm #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned DEPTH   = 16,
  parameter string       MEMTYPE = "block"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic              full,
  axis_uart_bridge_rx_if.master m_axis
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              wr_ok;
  logic              mem_rd;
  logic              pop;

  // count covers every stored word, including one held in the read register
  assign full  = (count == DEPTH_C);
  assign wr_ok = wren & ~full;
  assign pop   = m_axis.tvalid & m_axis.tready;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (mem_rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  if (MEMTYPE == "block") begin : g_block
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CW-1:0]     mem_cnt;

    assign mem_cnt = count - {{AW{1'b0}}, out_valid};
    assign mem_rd  = (mem_cnt != '0) && (!out_valid || m_axis.tready);

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                 out_valid <= 1'b0;
      else if (mem_rd)         out_valid <= 1'b1;
      else if (m_axis.tready)  out_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (mem_rd) out_data <= mem[rd_ptr];
    end

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
  end else begin : g_dist
    assign mem_rd        = pop;
    assign m_axis.tvalid = (count != '0);
    assign m_axis.tdata  = mem[rd_ptr];
  end

endmodule

// File: rtl/axis_uart_bridge_rx.sv
// 8N1 UART receiver packing N_BYTES bytes (first byte in [7:0]) into AXI-Stream words.
// Optional partial-word idle timeout: AXIS_UART_BRIDGE_RX_TIMEOUT_EN.
module axis_uart_bridge_rx
  import axis_uart_bridge_pkg::*;
#(
  parameter int unsigned UART_SPEED    = 115200,
  parameter int unsigned FREQ_HZ       = 100000000,
  parameter int unsigned N_BYTES       = 32,
  parameter int unsigned QUEUE_DEPTH   = 16,
  parameter string       QUEUE_MEMTYPE = "block",
  parameter int unsigned TIMEOUT_BITS  = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic UART_RX,
  axis_uart_bridge_rx_if.master m_axis,
  output logic FRAME_ERROR,
  output logic OVERFLOW
);
  localparam int unsigned BIT_CLKS  = bit_clks(FREQ_HZ, UART_SPEED);
  localparam int unsigned HALF_CLKS = BIT_CLKS / 2;
  localparam int unsigned CW        = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam int unsigned BCW       = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CW-1:0]  BIT_LIM   = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0]  HALF_LIM  = CW'(HALF_CLKS - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(N_BYTES - 1);

  rx_fsm state, state_next;

  logic                      rx_meta, rxs, rx_prev;
  logic [1:0]                sync_vld;
  logic                      fall;
  logic                      sample, cnt_clr;
  logic [CW-1:0]             clk_cnt;
  logic [2:0]                bit_cnt;
  logic [BYTE_W-1:0]         shreg;
  logic [BCW-1:0]            byte_cnt;
  logic [N_BYTES*BYTE_W-1:0] word_reg;
  logic                      push;
  logic                      full;
  logic                      rst;

`ifdef AXIS_UART_BRIDGE_RX_TIMEOUT_EN
  localparam logic [31:0] IDLE_LIM = 32'(TIMEOUT_BITS * BIT_CLKS - 1);
  logic [31:0] idle_cnt;
`endif

  // rx_prev only follows rxs once the synchroniser holds real line samples, so a
  // line that is already low when reset releases never looks like a start edge.
  assign fall = rx_prev & ~rxs;
  assign rst  = ~resetn;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE_ST;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE_ST: begin
        if (fall) begin
          state_next = START_ST;
          cnt_clr    = 1'b1;
        end
      end
      START_ST: begin
        if (clk_cnt == HALF_LIM) begin
          sample     = 1'b1;
          cnt_clr    = 1'b1;
          state_next = rxs ? IDLE_ST : DATA_ST;
        end
      end
      DATA_ST: begin
        if (clk_cnt == BIT_LIM) begin
          sample  = 1'b1;
          cnt_clr = 1'b1;
          if (bit_cnt == 3'd7) state_next = STOP_ST;
        end
      end
      STOP_ST: begin
        if (clk_cnt == BIT_LIM) begin
          sample     = 1'b1;
          cnt_clr    = 1'b1;
          state_next = IDLE_ST;
        end
      end
      default: state_next = IDLE_ST;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      sync_vld    <= '0;
      rx_prev     <= 1'b0;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      byte_cnt    <= '0;
      push        <= 1'b0;
      FRAME_ERROR <= 1'b0;
      OVERFLOW    <= 1'b0;
`ifdef AXIS_UART_BRIDGE_RX_TIMEOUT_EN
      idle_cnt    <= '0;
`endif
    end else begin
      rx_meta     <= UART_RX;
      rxs         <= rx_meta;
      sync_vld    <= {sync_vld[0], 1'b1};
      rx_prev     <= sync_vld[1] & rxs;
      push        <= 1'b0;
      FRAME_ERROR <= 1'b0;
      OVERFLOW    <= push & full;
      clk_cnt     <= (cnt_clr || state == IDLE_ST) ? '0 : clk_cnt + 1'b1;

      if (state == IDLE_ST && fall) bit_cnt <= '0;

      if (state == DATA_ST && sample) begin
        shreg   <= {rxs, shreg[BYTE_W-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == STOP_ST && sample) begin
        if (rxs) begin
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt <= '0;
            push     <= 1'b1;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end else begin
          FRAME_ERROR <= 1'b1;
          byte_cnt    <= '0;
        end
      end

`ifdef AXIS_UART_BRIDGE_RX_TIMEOUT_EN
      if (state == IDLE_ST && byte_cnt != '0 && !fall) begin
        if (idle_cnt == IDLE_LIM) begin
          idle_cnt <= '0;
          byte_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (state == STOP_ST && sample && rxs) begin
      for (int unsigned i = 0; i < N_BYTES; i++) begin
        if (byte_cnt == BCW'(i)) word_reg[i*BYTE_W +: BYTE_W] <= shreg;
      end
    end
  end

  fifo_out_sync_xpm #(
    .DATA_W  (N_BYTES * BYTE_W),
    .DEPTH   (QUEUE_DEPTH),
    .MEMTYPE (QUEUE_MEMTYPE)
  ) u_queue (
    .clk    (clk),
    .rst    (rst),
    .data   (word_reg),
    .wren   (push),
    .full   (full),
    .m_axis (m_axis)
  );

endmodule

// File: tb/tb_axis_uart_bridge_rx.sv
// Directed bench for axis_uart_bridge_rx: 10 clk per bit, 4-byte words, 4-deep queue.
`timescale 1ns/1ps
module tb_axis_uart_bridge_rx;

  logic clk = 1'b0;
  logic resetn;
  logic rx;
  logic frame_error;
  logic overflow;

  always #5 clk = ~clk;

  axis_uart_bridge_rx_if #(.DATA_W(32)) axis ();

  axis_uart_bridge_rx #(
    .UART_SPEED    (10000000),
    .FREQ_HZ       (100000000),
    .N_BYTES       (4),
    .QUEUE_DEPTH   (4),
    .QUEUE_MEMTYPE ("block"),
    .TIMEOUT_BITS  (32)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .UART_RX     (rx),
    .m_axis      (axis),
    .FRAME_ERROR (frame_error),
    .OVERFLOW    (overflow)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned stop_cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned fe_cnt = 0;
  int unsigned ov_cnt = 0;
  logic        tv_prev = 1'b0;
  logic [31:0] got[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (axis.tvalid && axis.tready) got.push_back(axis.tdata);
    if (frame_error) fe_cnt++;
    if (overflow) ov_cnt++;
    if (axis.tvalid && !tv_prev) rise_cyc = cyc;
    tv_prev = axis.tvalid;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      if (i == 9) stop_cyc = cyc;
      idle(10);
    end
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic test_reset();
    rx = 1'b1;
    axis.tready = 1'b1;
    resetn = 1'b0;
    idle(5);
    checks++;
    if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", axis.tvalid); end
    checks++;
    if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error got %b want 0", frame_error); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    resetn = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    int base;
    int lat;
    logic [31:0] w;
    base = got.size();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    idle(20);
    checks++;
    if (got.size() - base !== 1) begin errors++; $display("FAIL basic_count got %0d want 1", got.size() - base); end
    w = (got.size() > base) ? got[base] : 32'hxxxxxxxx;
    checks++;
    if (w !== 32'h44332211) begin errors++; $display("FAIL basic_word got %h want 44332211", w); end
    // stop sample lands 8 clk after the stop bit is driven; tvalid must follow within 4
    lat = int'(rise_cyc) - int'(stop_cyc);
    checks++;
    if (!(lat >= 0 && lat <= 12)) begin errors++; $display("FAIL basic_latency got %0d want 0..12", lat); end
  endtask

  task automatic test_frame_error();
    int base;
    int unsigned fe0;
    logic [31:0] w;
    base = got.size();
    fe0 = fe_cnt;
    send_byte(8'h99, 1'b1);
    send_byte(8'hA5, 1'b0);
    idle(10);
    send_word(32'h04030201);
    idle(20);
    checks++;
    if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL fe_pulses got %0d want 1", fe_cnt - fe0); end
    checks++;
    if (got.size() - base !== 1) begin errors++; $display("FAIL fe_count got %0d want 1", got.size() - base); end
    w = (got.size() > base) ? got[base] : 32'hxxxxxxxx;
    checks++;
    if (w !== 32'h04030201) begin errors++; $display("FAIL fe_word got %h want 04030201", w); end
  endtask

  task automatic test_glitch();
    int base;
    int unsigned fe0;
    logic [31:0] w;
    base = got.size();
    fe0 = fe_cnt;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    checks++;
    if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL glitch_fe got %0d want 0", fe_cnt - fe0); end
    checks++;
    if (got.size() - base !== 0) begin errors++; $display("FAIL glitch_out got %0d want 0", got.size() - base); end
    send_word(32'h5A6B7C8D);
    idle(20);
    w = (got.size() > base) ? got[base] : 32'hxxxxxxxx;
    checks++;
    if (w !== 32'h5A6B7C8D) begin errors++; $display("FAIL glitch_next_word got %h want 5a6b7c8d", w); end
  endtask

  task automatic test_overflow();
    int base;
    int unsigned ov0;
    logic [31:0] words [5];
    logic [31:0] w;
    words[0] = 32'hA4A3A2A1;
    words[1] = 32'hB4B3B2B1;
    words[2] = 32'hC4C3C2C1;
    words[3] = 32'hD4D3D2D1;
    words[4] = 32'hE4E3E2E1;
    base = got.size();
    ov0 = ov_cnt;
    axis.tready = 1'b0;
    for (int i = 0; i < 5; i++) send_word(words[i]);
    idle(20);
    checks++;
    if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", ov_cnt - ov0); end
    checks++;
    if (got.size() - base !== 0) begin errors++; $display("FAIL ovf_stalled got %0d want 0", got.size() - base); end
    checks++;
    if (axis.tvalid !== 1'b1) begin errors++; $display("FAIL ovf_tvalid got %b want 1", axis.tvalid); end
    checks++;
    if (axis.tdata !== 32'hA4A3A2A1) begin errors++; $display("FAIL ovf_head got %h want a4a3a2a1", axis.tdata); end
    axis.tready = 1'b1;
    idle(20);
    checks++;
    if (got.size() - base !== 4) begin errors++; $display("FAIL ovf_drain got %0d want 4", got.size() - base); end
    for (int i = 0; i < 4; i++) begin
      w = (got.size() > base + i) ? got[base + i] : 32'hxxxxxxxx;
      checks++;
      if (w !== words[i]) begin errors++; $display("FAIL ovf_word%0d got %h want %h", i, w, words[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int unsigned fe0;
    logic [31:0] w;
    base = got.size();
    fe0 = fe_cnt;
    send_byte(8'h12, 1'b1);
    // byte 0x40: start and bits 0..3 are all low, reset lands in bit 3
    rx = 1'b0;
    idle(45);
    resetn = 1'b0;
    idle(2);
    checks++;
    if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid got %b want 0", axis.tvalid); end
    checks++;
    if (frame_error !== 1'b0) begin errors++; $display("FAIL rst_mid_fe got %b want 0", frame_error); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf got %b want 0", overflow); end
    idle(3);
    resetn = 1'b1;
    idle(20);
    rx = 1'b1;
    idle(20);
    send_word(32'h87654321);
    idle(20);
    checks++;
    if (got.size() - base !== 1) begin errors++; $display("FAIL rst_mid_count got %0d want 1", got.size() - base); end
    w = (got.size() > base) ? got[base] : 32'hxxxxxxxx;
    checks++;
    if (w !== 32'h87654321) begin errors++; $display("FAIL rst_mid_word got %h want 87654321", w); end
    checks++;
    if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL rst_mid_fe_count got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_timeout();
    int base;
    logic [31:0] w;
    logic [31:0] exp_w;
    base = got.size();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    idle(400);
`ifdef AXIS_UART_BRIDGE_RX_TIMEOUT_EN
    send_word(32'hC4C3C2C1);
    exp_w = 32'hC4C3C2C1;
`else
    send_byte(8'hC1, 1'b1);
    send_byte(8'hC2, 1'b1);
    exp_w = 32'hC2C1BBAA;
`endif
    idle(20);
    checks++;
    if (got.size() - base !== 1) begin errors++; $display("FAIL timeout_count got %0d want 1", got.size() - base); end
    w = (got.size() > base) ? got[base] : 32'hxxxxxxxx;
    checks++;
    if (w !== exp_w) begin errors++; $display("FAIL timeout_word got %h want %h", w, exp_w); end
  endtask

  initial begin
    rx = 1'b1;
    resetn = 1'b0;
    axis.tready = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_frame_error();
    test_glitch();
    test_overflow();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
